efpga_cfg_frame_loader: RTL and testbench

Configuration-memory stage that directly drives the `mem`/`mem_inv` select pairs of the eFPGA routing and LUT multiplexer primitives.
- Accepts configuration words over a valid/ready handshake and assembles them into a shadow register.
- On an explicit commit, transfers the complete frame atomically to the active register, so downstream transmission gates never see a partially loaded select pattern.
- Sits between the programming interface and a group of mux instances.

---
 rtl/efpga_cfg_frame_loader.sv | 74 +++++++
 tb/tb_efpga_cfg_frame_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/efpga_cfg_frame_loader.sv
// efpga_cfg_frame_loader: shadow-buffered config frame loader driving mux mem/mem_inv select pairs
module efpga_cfg_frame_loader #(
  parameter int NUM_BITS = 16,
  parameter int WORD_W   = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              commit,
  output logic              load_done,
  output logic              cfg_updated,
  output logic              err,
  output logic [0:NUM_BITS-1] mem,
  output logic [0:NUM_BITS-1] mem_inv
);
  localparam int NUM_WORDS = NUM_BITS / WORD_W;
  localparam int CW = $clog2(NUM_WORDS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [0:NUM_BITS-1] shadow, shadow_n;
  logic accept, xfer, err_n;
  // start outranks commit and data; commit in LOAD blocks the word that cycle
  assign accept = (state == LOAD) && in_valid && !start && !commit;
  assign xfer = (state == FULL) && commit && !start;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shadow_n = shadow;
    err_n = err;
    if (start) begin
      state_n = LOAD;
      cnt_n = '0;
      err_n = 1'b0;
    end else if (commit) begin
      state_n = (state == FULL) ? IDLE : state;
      err_n = (state == FULL) ? err : 1'b1;
    end else if (accept) begin
      cnt_n = cnt + CW'(1);
      state_n = (cnt == CW'(NUM_WORDS - 1)) ? FULL : LOAD;
      for (int k = 0; k < NUM_WORDS; k++)
        for (int j = 0; j < WORD_W; j++)
          if (cnt == CW'(k)) shadow_n[k*WORD_W+j] = in_data[j];
    end
  end
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      mem <= '0;
      mem_inv <= '1;
      in_ready <= 1'b0;
      load_done <= 1'b0;
      cfg_updated <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shadow <= shadow_n;
      in_ready <= (state_n == LOAD);
      load_done <= (state_n == FULL);
      cfg_updated <= xfer;
      err <= err_n;
      if (xfer) begin
        mem <= shadow;
        mem_inv <= ~shadow;
      end
    end
  end
endmodule

// File: tb/tb_efpga_cfg_frame_loader.sv
// tb_efpga_cfg_frame_loader: table-driven cycle checks plus reset sequences
module tb_efpga_cfg_frame_loader;
  logic prog_clk = 0, prog_reset_n = 0;
  logic start = 0, in_valid = 0, commit = 0;
  logic [7:0] in_data = 0;
  logic in_ready, load_done, cfg_updated, err;
  logic [0:15] mem, mem_inv;
  int tests = 0, fails = 0;

  efpga_cfg_frame_loader dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .commit(commit), .load_done(load_done), .cfg_updated(cfg_updated),
    .err(err), .mem(mem), .mem_inv(mem_inv)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic st, cm, v;
    logic [7:0] d;
    logic rdy, done, upd, er;
    logic [15:0] m;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic rdy, done, upd, er, input logic [15:0] m);
    chk("in_ready", idx, {15'd0, in_ready}, {15'd0, rdy});
    chk("load_done", idx, {15'd0, load_done}, {15'd0, done});
    chk("cfg_updated", idx, {15'd0, cfg_updated}, {15'd0, upd});
    chk("err", idx, {15'd0, err}, {15'd0, er});
    chk("mem", idx, mem, m);
    chk("mem_inv", idx, mem_inv, ~m);
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // mem values are written MSB-first as mem[0..15]; word bytes appear bit-reversed
  initial begin
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA53C});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA53C});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA53C});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA53C});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA53C});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFF00});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFF00});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h44CC});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h44CC});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 16'h44CC});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h44CC});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 16'h44CC});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 16'h44CC});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h44CC});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 16'h44CC});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h44CC});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF00F});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF00F});

    step();
    step();
    chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    prog_reset_n = 1;
    step();
    chk_all(-2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    foreach (tbl[i]) begin
      start = tbl[i].st;
      commit = tbl[i].cm;
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      step();
      chk_all(i, tbl[i].rdy, tbl[i].done, tbl[i].upd, tbl[i].er, tbl[i].m);
    end
    start = 0; commit = 0; in_valid = 0;

    // reset mid-load: currently in LOAD with mem = F00F
    in_valid = 1; in_data = 8'h5A;
    step();
    chk_all(100, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF00F);
    in_valid = 0; prog_reset_n = 0;
    step();
    chk_all(101, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    prog_reset_n = 1;
    step();
    chk_all(102, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    commit = 1;
    step();
    commit = 0;
    chk_all(103, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

    // reset while FULL discards the complete frame
    start = 1;
    step();
    start = 0; in_valid = 1; in_data = 8'hC3;
    step();
    step();
    in_valid = 0;
    chk_all(104, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    prog_reset_n = 0;
    step();
    prog_reset_n = 1;
    commit = 1;
    step();
    commit = 0;
    chk_all(105, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
